hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001: Parameter REG_ADDR_W, default 5, register-index width.
REQ-002: Parameter FWD_EN, default 1; 1 = forwarding mode, 0 = interlock-only mode.
REQ-003: Parameter LOAD_LAT, default 1, range 1..4; bubbles inserted per load-use hazard.
REQ-004: Parameter CNT_W, default 16, width of each performance counter.
REQ-005: Ports, as name / direction / width / meaning:
- clk  in  1  clock; one clock domain, all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- Rs1D, Rs2D  in  REG_ADDR_W  source registers of the instruction in Decode
- Rs1E, Rs2E  in  REG_ADDR_W  source registers of the instruction in Execute
- RdE, RdM, RdW  in  REG_ADDR_W  destination register in Execute / Memory / Writeback
- RegWriteE, RegWriteM, RegWriteW  in  1  destination-write enable in Execute / Memory / Writeback
- ResultSrcE  in  2  result select in Execute; 2'b01 = load
- PCSrcE  in  1  taken branch or jump resolved in Execute
- cnt_clr  in  1  synchronous clear of both performance counters
- StallF, StallD  out  1  hold the PC register / hold the F->D pipeline register
- FlushD, FlushE  out  1  bubble the F->D / D->E pipeline register
- ForwardAE, ForwardBE  out  2  ALU operand A / B source select
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Function
REQ-006: A "match" requires equal indices, the producer's RegWrite = 1, and a producer Rd != 0; register x0 never matches.
REQ-007: When FWD_EN=1, ForwardAE is combinational: 2'b10 on a match RdM==Rs1E; otherwise 2'b01 on a match RdW==Rs1E; otherwise 2'b00. Memory stage has priority.
REQ-008: ForwardBE follows the same rule as REQ-007 using Rs2E.
REQ-009: When FWD_EN=0, ForwardAE and ForwardBE are tied to 2'b00.
REQ-010: A hazard is detected (lu_det) in either mode:
- FWD_EN=1: ResultSrcE==2'b01 and RdE matches Rs1D or Rs2D.
- FWD_EN=0: RdE, RdM or RdW matches Rs1D or Rs2D.
REQ-011: State machine, two states, RUN and HOLD, plus a down-counter bub_cnt of width 3.
REQ-012: In RUN, when lu_det=1 and PCSrcE=0:
- StallF=StallD=FlushE=1 in the same cycle;
- if LOAD_LAT>1, go to HOLD next cycle with bub_cnt=LOAD_LAT-1; otherwise stay in RUN.
REQ-013: In HOLD, StallF=StallD=FlushE=1 and bub_cnt decrements each cycle; return to RUN in the cycle after bub_cnt reaches 1.
REQ-014: In FWD_EN=0 mode, HOLD is not used: the stall is asserted combinationally for as long as lu_det=1.
REQ-015: PCSrcE=1 asserts FlushD=FlushE=1 in the same cycle.
REQ-016: PCSrcE=1 has priority over any stall: StallF=StallD=0, the state goes to RUN and bub_cnt is cleared.
REQ-017: Outside REQ-012..REQ-016 all of StallF, StallD, FlushD and FlushE are 0.
REQ-018: stall_cnt increments by 1 in every cycle StallD=1; it saturates at all-ones (no wrap).
REQ-019: flush_cnt increments by 1 in every cycle PCSrcE=1; it saturates at all-ones.
REQ-020: cnt_clr=1 zeroes both counters next cycle; cnt_clr has priority over an increment in the same cycle.
REQ-021: Every output other than the counters depends only on the current inputs and the current state (zero-cycle latency).

Reset
REQ-022: While rst=0 at a rising edge, the next state is RUN, bub_cnt=0, stall_cnt=0 and flush_cnt=0.
REQ-023: While rst=0, StallF, StallD, FlushD and FlushE are 0 (reset overrides state, including mid-HOLD). ForwardAE/BE still follow REQ-007..REQ-009.
REQ-024: The first cycle after rst returns to 1 evaluates hazards normally from RUN.

Verification
REQ-025: Forward priority, FWD_EN=1: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=2'b10; with RegWriteM=0 -> ForwardAE=2'b01; with all indices 0 -> 2'b00.
REQ-026: Load-use, LOAD_LAT=3: ResultSrcE=2'b01, RdE=7, Rs2D=7 for one cycle -> StallD=FlushE=1 for exactly 3 consecutive cycles, then 0; stall_cnt=3.
REQ-027: Branch during HOLD, LOAD_LAT=3: PCSrcE=1 in the second stall cycle -> that cycle has StallD=0, FlushD=FlushE=1; next cycle all four controls are 0; flush_cnt=1.
REQ-028: Interlock mode, FWD_EN=0: RdW=3, RegWriteW=1, Rs1D=3 -> StallD=1 while the match holds; ForwardAE=ForwardBE=2'b00 throughout.
REQ-029: Saturation and clear, CNT_W=4: hold a stall for 20 cycles -> stall_cnt stays at 15; then cnt_clr=1 concurrent with a stall -> stall_cnt=0.
REQ-030: Reset mid-HOLD: drive rst=0 in the second stall cycle -> next cycle StallD=0, state RUN, both counters 0.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding select, load-use / interlock stall
// sequencing with a RUN/HOLD bubble FSM, and saturating stall/flush counters.
module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  cnt_clr,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  o_dbg_state
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [2:0] BUB_INIT = 3'(LOAD_LAT - 1);
  localparam bit         USE_HOLD = (FWD_EN != 0) && (LOAD_LAT > 1);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_bub_cnt, w_bub_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_lu_fwd, w_lu_ilk, w_lu_det;

  // x0 is hard-wired zero, so it never creates a dependency.
  function automatic logic match(input logic [REG_ADDR_W-1:0] rd,
                                 input logic                  we,
                                 input logic [REG_ADDR_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (FWD_EN != 0) begin
      if (match(RdM, RegWriteM, Rs1E))      ForwardAE = 2'b10;
      else if (match(RdW, RegWriteW, Rs1E)) ForwardAE = 2'b01;
      if (match(RdM, RegWriteM, Rs2E))      ForwardBE = 2'b10;
      else if (match(RdW, RegWriteW, Rs2E)) ForwardBE = 2'b01;
    end
  end

  assign w_lu_fwd = (ResultSrcE == 2'b01) &&
                    (match(RdE, RegWriteE, Rs1D) || match(RdE, RegWriteE, Rs2D));
  assign w_lu_ilk = match(RdE, RegWriteE, Rs1D) || match(RdE, RegWriteE, Rs2D) ||
                    match(RdM, RegWriteM, Rs1D) || match(RdM, RegWriteM, Rs2D) ||
                    match(RdW, RegWriteW, Rs1D) || match(RdW, RegWriteW, Rs2D);
  assign w_lu_det = (FWD_EN != 0) ? w_lu_fwd : w_lu_ilk;

  // Branch flush beats any stall; reset forces the controls low regardless of state.
  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    w_state_nxt = r_state;
    w_bub_nxt   = r_bub_cnt;
    if (PCSrcE) begin
      FlushD      = 1'b1;
      FlushE      = 1'b1;
      w_state_nxt = RUN;
      w_bub_nxt   = 3'd0;
    end else if (r_state == HOLD) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
      if (r_bub_cnt <= 3'd1) begin
        w_state_nxt = RUN;
        w_bub_nxt   = 3'd0;
      end else begin
        w_bub_nxt = r_bub_cnt - 3'd1;
      end
    end else if (w_lu_det) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
      if (USE_HOLD) begin
        w_state_nxt = HOLD;
        w_bub_nxt   = BUB_INIT;
      end
    end
    if (!rst) begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= RUN;
      r_bub_cnt <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bub_cnt <= w_bub_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (PCSrcE && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign o_dbg_state = logic'(r_state);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a forwarding instance (LOAD_LAT=3) and an
// interlock instance (LOAD_LAT=1), both with 4-bit counters, driven in parallel.
module tb_hazard_unit;

  logic       clk, rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, PCSrcE, cnt_clr;
  logic [1:0] ResultSrcE;

  logic       f_StallF, f_StallD, f_FlushD, f_FlushE, f_state;
  logic [1:0] f_FwdA, f_FwdB;
  logic [3:0] f_stall_cnt, f_flush_cnt;
  logic       i_StallF, i_StallD, i_FlushD, i_FlushE, i_state;
  logic [1:0] i_FwdA, i_FwdB;
  logic [3:0] i_stall_cnt, i_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1), .LOAD_LAT(3), .CNT_W(4)) u_fwd (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
    .StallF(f_StallF), .StallD(f_StallD), .FlushD(f_FlushD), .FlushE(f_FlushE),
    .ForwardAE(f_FwdA), .ForwardBE(f_FwdB), .stall_cnt(f_stall_cnt),
    .flush_cnt(f_flush_cnt), .o_dbg_state(f_state)
  );

  hazard_unit #(.REG_ADDR_W(5), .FWD_EN(0), .LOAD_LAT(1), .CNT_W(4)) u_ilk (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
    .StallF(i_StallF), .StallD(i_StallD), .FlushD(i_FlushD), .FlushE(i_FlushE),
    .ForwardAE(i_FwdA), .ForwardBE(i_FwdB), .stall_cnt(i_stall_cnt),
    .flush_cnt(i_flush_cnt), .o_dbg_state(i_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the edge, checks follow 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, PCSrcE, cnt_clr} = '0;
    ResultSrcE = 2'b00;
  endtask

  task automatic load_use();
    ResultSrcE = 2'b01;
    RdE        = 5'd7;
    RegWriteE  = 1'b1;
    Rs2D       = 5'd7;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic check_ctrl(input string tag, input logic sf, input logic sd,
                            input logic fd, input logic fe);
    check({tag, ".StallF"}, 32'(f_StallF), 32'(sf));
    check({tag, ".StallD"}, 32'(f_StallD), 32'(sd));
    check({tag, ".FlushD"}, 32'(f_FlushD), 32'(fd));
    check({tag, ".FlushE"}, 32'(f_FlushE), 32'(fe));
  endtask

  initial begin
    rst = 1'b0;
    idle();
    // reset with a load-use hazard and forwardable operand present
    load_use();
    RdM = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1;
    tick();
    tick();
    settle();
    check_ctrl("rst_ctrl", 0, 0, 0, 0);
    check("rst_fwdA", 32'(f_FwdA), 32'd2);
    check("rst_state", 32'(f_state), 32'd0);
    check("rst_stall_cnt", 32'(f_stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(f_flush_cnt), 32'd0);

    rst = 1'b1;
    idle();
    tick();

    // forwarding priority
    RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    settle();
    check("fwdA_mem", 32'(f_FwdA), 32'd2);
    check("ilk_fwdA_tied", 32'(i_FwdA), 32'd0);
    RegWriteM = 1'b0;
    settle();
    check("fwdA_wb", 32'(f_FwdA), 32'd1);
    RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; RegWriteM = 1'b1;
    settle();
    check("fwdA_x0", 32'(f_FwdA), 32'd0);
    idle();
    RdW = 5'd9; RegWriteW = 1'b1; Rs2E = 5'd9; RdM = 5'd4; RegWriteM = 1'b1;
    settle();
    check("fwdB_wb", 32'(f_FwdB), 32'd1);
    check("fwdA_none", 32'(f_FwdA), 32'd0);

    // load into x0 is not a hazard
    idle();
    ResultSrcE = 2'b01; RdE = 5'd0; RegWriteE = 1'b1;
    settle();
    check_ctrl("lu_x0", 0, 0, 0, 0);
    tick();

    // load-use with LOAD_LAT=3: exactly three stall cycles
    idle();
    clear_counters();
    load_use();
    settle();
    check_ctrl("lu_c0", 1, 1, 0, 1);
    tick();
    idle();
    settle();
    check_ctrl("lu_c1", 1, 1, 0, 1);
    check("lu_c1_state", 32'(f_state), 32'd1);
    tick();
    check_ctrl("lu_c2", 1, 1, 0, 1);
    tick();
    check_ctrl("lu_c3", 0, 0, 0, 0);
    check("lu_stall_cnt", 32'(f_stall_cnt), 32'd3);
    check("lu_state_run", 32'(f_state), 32'd0);

    // branch in the second stall cycle cancels HOLD
    clear_counters();
    load_use();
    tick();
    idle();
    PCSrcE = 1'b1;
    settle();
    check_ctrl("br_hold", 0, 0, 1, 1);
    tick();
    PCSrcE = 1'b0;
    settle();
    check_ctrl("br_after", 0, 0, 0, 0);
    check("br_state", 32'(f_state), 32'd0);
    check("br_flush_cnt", 32'(f_flush_cnt), 32'd1);

    // interlock-only instance
    idle();
    tick();
    RdW = 5'd3; RegWriteW = 1'b1; Rs1D = 5'd3; Rs1E = 5'd3;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("ilk_stallD", 32'(i_StallD), 32'd1);
      check("ilk_flushE", 32'(i_FlushE), 32'd1);
      check("ilk_fwdA", 32'(i_FwdA), 32'd0);
      check("ilk_fwdB", 32'(i_FwdB), 32'd0);
      check("ilk_fwd_inst_nostall", 32'(f_StallD), 32'd0);
      check("fwd_inst_fwdA", 32'(f_FwdA), 32'd1);
      tick();
    end
    RegWriteW = 1'b0;
    settle();
    check("ilk_nowrite", 32'(i_StallD), 32'd0);
    idle();
    RdM = 5'd12; RegWriteM = 1'b1; Rs2D = 5'd12;
    settle();
    check("ilk_mem_stallD", 32'(i_StallD), 32'd1);
    tick();
    check("ilk_no_hold", 32'(i_state), 32'd0);
    idle();
    settle();
    check("ilk_release", 32'(i_StallD), 32'd0);

    // counter saturation and clear priority
    clear_counters();
    load_use();
    for (int k = 0; k < 20; k++) tick();
    check("sat_stall_cnt", 32'(f_stall_cnt), 32'd15);
    cnt_clr = 1'b1;
    settle();
    check("sat_stall_during_clr", 32'(f_StallD), 32'd1);
    tick();
    cnt_clr = 1'b0;
    check("clr_stall_cnt", 32'(f_stall_cnt), 32'd0);
    tick();
    check("post_clr_stall_cnt", 32'(f_stall_cnt), 32'd1);
    idle();
    tick();
    tick();
    PCSrcE = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("flush_cnt_10", 32'(f_flush_cnt), 32'd10);
    for (int k = 0; k < 8; k++) tick();
    check("flush_cnt_sat", 32'(f_flush_cnt), 32'd15);
    idle();
    tick();

    // reset in the middle of HOLD
    load_use();
    tick();
    idle();
    rst = 1'b0;
    settle();
    check_ctrl("rst_hold", 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    settle();
    check_ctrl("rst_hold_next", 0, 0, 0, 0);
    check("rst_hold_state", 32'(f_state), 32'd0);
    check("rst_hold_stall_cnt", 32'(f_stall_cnt), 32'd0);
    check("rst_hold_flush_cnt", 32'(f_flush_cnt), 32'd0);
    load_use();
    settle();
    check_ctrl("post_rst_lu", 1, 1, 0, 1);
    tick();
    idle();
    tick();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
